// File: rtl/spike_dec_pkg.sv
// Shared types, default widths and the saturating increment used by the
// spike rate decoder and its ISI timer.
package spike_dec_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_WIN_W = 8;
    localparam int DEF_ISI_W = 8;

    // Callers narrow the result back to their own width with a size cast.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/spike_rate_decoder_isi_timer.sv
// Rising-edge detector on the spike line plus the inter-spike interval timer.
// The event strobe is shared with the parent window counter.
module isi_timer
    import spike_dec_pkg::*;
#(
    parameter int ISI_W = DEF_ISI_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             spike_in,
    output logic             spike_event,
    output logic [ISI_W-1:0] isi_out,
    output logic             isi_valid
);

    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    logic             spike_q;
    logic             armed;
    logic [ISI_W-1:0] isi_cnt;
    logic [ISI_W-1:0] isi_inc;

    assign spike_event = spike_in & ~spike_q;
    assign isi_inc     = ISI_W'(sat_inc(32'(isi_cnt), 32'(ISI_MAX)));

    always_ff @(posedge clk) begin
        if (reset) begin
            spike_q <= 1'b0;
        end else begin
            spike_q <= spike_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            armed     <= 1'b0;
            isi_cnt   <= '0;
            isi_out   <= '0;
            isi_valid <= 1'b0;
        end else if (!run) begin
            armed     <= 1'b0;
            isi_cnt   <= '0;
            isi_valid <= 1'b0;
        end else begin
            isi_valid <= 1'b0;
            if (spike_event) begin
                // First event only arms; the interval is measured from here.
                if (armed) begin
                    isi_out   <= isi_inc;
                    isi_valid <= 1'b1;
                end
                armed   <= 1'b1;
                isi_cnt <= '0;
            end else begin
                isi_cnt <= isi_inc;
            end
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Turns a neuron spike line back into a per-window spike count behind a
// valid/ready output register, plus the latest inter-spike interval.
module spike_rate_decoder
    import spike_dec_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int WIN_W = DEF_WIN_W,
    parameter int ISI_W = DEF_ISI_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] window_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_sat,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun,
    output logic [ISI_W-1:0] isi_out,
    output logic             isi_valid,
    output logic             dbg_state
);

    // Handshake: a result transfers on a cycle where rate_valid & rate_ready
    // are both high; rate_valid is a pure register output and rate_out/rate_sat
    // do not change while rate_valid is high and rate_ready is low.

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [WIN_W-1:0] len_q;
    logic [WIN_W-1:0] wcnt;
    logic [WIN_W-1:0] len_last;
    logic [CNT_W-1:0] scount;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] result_cnt;
    logic             sat_q;
    logic             ev_sat;
    logic             result_sat;
    logic             enable_q;
    logic             active;
    logic             win_done;
    logic             load;
    logic             spike_event;

    assign active     = (state == RUN) && enable;
    assign len_last   = len_q - WIN_W'(1);
    assign win_done   = active && (wcnt == len_last);
    assign cnt_inc    = CNT_W'(sat_inc(32'(scount), 32'(CNT_MAX)));
    assign ev_sat     = spike_event && (scount == CNT_MAX);
    assign result_cnt = spike_event ? cnt_inc : scount;
    assign result_sat = sat_q | ev_sat;
    assign load       = win_done && (!rate_valid || rate_ready);
    assign dbg_state  = state;

    isi_timer #(
        .ISI_W(ISI_W)
    ) u_isi_timer (
        .clk        (clk),
        .reset      (reset),
        .run        (active),
        .spike_in   (spike_in),
        .spike_event(spike_event),
        .isi_out    (isi_out),
        .isi_valid  (isi_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= '0;
            wcnt       <= '0;
            scount     <= '0;
            sat_q      <= 1'b0;
            enable_q   <= 1'b0;
            rate_out   <= '0;
            rate_sat   <= 1'b0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            enable_q <= enable;

            case (state)
                IDLE: begin
                    wcnt   <= '0;
                    scount <= '0;
                    sat_q  <= 1'b0;
                    if (enable) begin
                        state <= RUN;
                        len_q <= window_len;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state  <= IDLE;
                        wcnt   <= '0;
                        scount <= '0;
                        sat_q  <= 1'b0;
                    end else if (win_done) begin
                        // Back-to-back windows: the next one starts right away.
                        wcnt   <= '0;
                        scount <= '0;
                        sat_q  <= 1'b0;
                        len_q  <= window_len;
                    end else begin
                        wcnt <= wcnt + WIN_W'(1);
                        if (spike_event) begin
                            scount <= cnt_inc;
                            sat_q  <= sat_q | ev_sat;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (win_done) begin
                if (load) begin
                    rate_out   <= result_cnt;
                    rate_sat   <= result_sat;
                    rate_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rate_valid && rate_ready) begin
                rate_valid <= 1'b0;
            end

            if (enable_q && !enable) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: expected rates and ISIs are queued by
// the stimulus and popped by an independent output monitor.
module tb_spike_rate_decoder;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       spike_in;
    logic [7:0] window_len;
    logic [3:0] rate_out;
    logic       rate_sat;
    logic       rate_valid;
    logic       rate_ready;
    logic       overrun;
    logic [7:0] isi_out;
    logic       isi_valid;
    logic       dbg_state;

    logic [4:0] rate_q[$];
    logic [7:0] isi_q[$];
    int         total;
    int         bad;

    spike_rate_decoder #(
        .CNT_W(4),
        .WIN_W(8),
        .ISI_W(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .spike_in  (spike_in),
        .window_len(window_len),
        .rate_out  (rate_out),
        .rate_sat  (rate_sat),
        .rate_valid(rate_valid),
        .rate_ready(rate_ready),
        .overrun   (overrun),
        .isi_out   (isi_out),
        .isi_valid (isi_valid),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset      = 1'b1;
        enable     = 1'b0;
        spike_in   = 1'b0;
        rate_ready = 1'b0;
        window_len = 8'd0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic start_window(input logic [7:0] len);
        enable     = 1'b1;
        window_len = len;
        tick();
    endtask

    task automatic run_window(input int len, input logic [63:0] pat);
        for (int i = 0; i < len; i++) begin
            spike_in = pat[i];
            tick();
        end
        spike_in = 1'b0;
    endtask

    task automatic stop_run();
        enable = 1'b0;
        tick();
        repeat (3) tick();
    endtask

    // Output monitor: pops an expectation for each transfer and each ISI pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (rate_valid && rate_ready) begin
                if (rate_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rate_unexpected: got %0d with no expected value", rate_out);
                end else begin
                    check("rate_result", int'({rate_sat, rate_out}), int'(rate_q.pop_front()));
                end
            end
            if (isi_valid) begin
                if (isi_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL isi_unexpected: got %0d with no expected value", isi_out);
                end else begin
                    check("isi_result", int'(isi_out), int'(isi_q.pop_front()));
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        reset_dut();
        check("reset_rate_out", int'(rate_out), 0);
        check("reset_rate_sat", int'(rate_sat), 0);
        check("reset_rate_valid", int'(rate_valid), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_isi_out", int'(isi_out), 0);
        check("reset_isi_valid", int'(isi_valid), 0);
        check("reset_state", int'(dbg_state), 0);

        // Basic rate: spikes on cycles 0,3,6,9 of a 10-cycle window.
        rate_ready = 1'b1;
        rate_q.push_back({1'b0, 4'd4});
        repeat (3) isi_q.push_back(8'd3);
        start_window(8'd10);
        check("run_state", int'(dbg_state), 1);
        run_window(9, 64'h249);
        check("basic_valid_early", int'(rate_valid), 0);
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        check("basic_valid_latency", int'(rate_valid), 1);
        check("basic_rate_out", int'(rate_out), 4);
        stop_run();

        // Held level: high for 5 cycles counts once, no ISI.
        rate_q.push_back({1'b0, 4'd1});
        start_window(8'd10);
        run_window(10, 64'h7C);
        stop_run();

        // Saturation: 20 edges into a 4-bit counter.
        rate_q.push_back({1'b1, 4'd15});
        repeat (19) isi_q.push_back(8'd2);
        start_window(8'd40);
        run_window(40, 64'h55_5555_5555);
        stop_run();

        // Backpressure and overrun.
        rate_ready = 1'b0;
        rate_q.push_back({1'b0, 4'd4});
        rate_q.push_back({1'b0, 4'd1});
        repeat (5) isi_q.push_back(8'd3);
        isi_q.push_back(8'd6);
        start_window(8'd10);
        run_window(10, 64'h249);
        run_window(10, 64'h24);
        check("bp_overrun_set", int'(overrun), 1);
        check("bp_valid_held", int'(rate_valid), 1);
        check("bp_rate_kept", int'(rate_out), 4);
        run_window(9, 64'h2);
        rate_ready = 1'b1;
        tick();
        rate_ready = 1'b0;
        check("bp_valid_reload", int'(rate_valid), 1);
        check("bp_rate_reload", int'(rate_out), 1);
        check("bp_overrun_sticky", int'(overrun), 1);
        enable     = 1'b0;
        rate_ready = 1'b1;
        tick();
        check("bp_overrun_clear", int'(overrun), 0);
        check("bp_valid_drained", int'(rate_valid), 0);
        repeat (3) tick();

        // Disable at window cycle 5, then a fresh 4-cycle window.
        isi_q.push_back(8'd2);
        rate_q.push_back({1'b0, 4'd1});
        start_window(8'd10);
        run_window(5, 64'hA);
        enable = 1'b0;
        tick();
        repeat (3) tick();
        check("dis_no_result", int'(rate_valid), 0);
        start_window(8'd4);
        run_window(4, 64'h4);
        check("dis_fresh_valid", int'(rate_valid), 1);
        check("dis_fresh_count", int'(rate_out), 1);
        stop_run();

        // Reset while a result is pending.
        rate_ready = 1'b0;
        isi_q.push_back(8'd2);
        start_window(8'd4);
        run_window(4, 64'h5);
        check("rst_pending_valid", int'(rate_valid), 1);
        check("rst_pending_rate", int'(rate_out), 2);
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        check("rst_rate_out", int'(rate_out), 0);
        check("rst_rate_valid", int'(rate_valid), 0);
        check("rst_rate_sat", int'(rate_sat), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_isi_out", int'(isi_out), 0);
        check("rst_isi_valid", int'(isi_valid), 0);
        check("rst_state", int'(dbg_state), 0);
        reset = 1'b0;
        tick();

        // ISI saturation across a 256-cycle window (window_len = 0).
        rate_ready = 1'b1;
        rate_q.push_back({1'b0, 4'd1});
        isi_q.push_back(8'd255);
        start_window(8'd0);
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        repeat (254) tick();
        check("len0_valid_early", int'(rate_valid), 0);
        tick();
        check("len0_valid_256", int'(rate_valid), 1);
        repeat (44) tick();
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        repeat (5) tick();
        stop_run();

        repeat (5) tick();
        check("rate_queue_empty", rate_q.size(), 0);
        check("isi_queue_empty", isi_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
